// File: rtl/fx_mult_sat_pipe.sv
// 3-stage pipelined signed fixed-point multiplier with round/saturate, valid/ready backpressure and overflow flagging.
// Define FX_MULT_SAT_COUNT_EN to build the saturation event counter; otherwise sat_count is tied to 0.
module fx_mult_sat_pipe #(
    parameter int N     = 25,
    parameter int F     = 14,
    parameter int RND   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     resultado,
    output logic             sat_pos,
    output logic             sat_neg,
    input  logic             clr_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] sat_count
);

    localparam int PW   = 2 * N;
    localparam int TOPW = PW - (N + F - 1) + 1;
    localparam logic [PW:0]  RND_ADD = (RND != 0) ? ((PW + 1)'(1) << (F - 1)) : '0;
    localparam logic [N-1:0] POS_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] NEG_MAX = {1'b1, {(N-1){1'b0}}};

    logic          v1_q, v2_q, v3_q;
    logic [N-1:0]  a_q, b_q;
    logic [PW-1:0] p_q, p_d;
    logic [N-1:0]  res_q, res_d;
    logic          sat_pos_q, sat_pos_d, sat_neg_q, sat_neg_d;
    logic          ovf_q;

    logic          stall, advance, handshake, sat_event;
    logic [PW:0]   q_full;
    logic [TOPW-1:0] q_top;
    logic          in_range;
    logic          unused_q_lsbs;

    assign stall     = v3_q && !out_ready;
    assign advance   = !stall;
    assign handshake = v3_q && out_ready;
    assign sat_event = handshake && (sat_pos_q || sat_neg_q);

    // Operands are sign-extended to 2N bits so the product cannot wrap.
    assign p_d = $signed({{N{a_q[N-1]}}, a_q}) * $signed({{N{b_q[N-1]}}, b_q});

    always_comb begin
        q_full    = {p_q[PW-1], p_q} + RND_ADD;
        q_top     = q_full[PW:N+F-1];
        in_range  = (&q_top) || !(|q_top);
        sat_pos_d = !in_range && !q_full[PW];
        sat_neg_d = !in_range &&  q_full[PW];
        res_d     = q_full[N+F-1:F];
        if (sat_pos_d) begin
            res_d = POS_MAX;
        end else if (sat_neg_d) begin
            res_d = NEG_MAX;
        end
    end

    assign unused_q_lsbs = ^q_full[F-1:0];

    // NOTE: datapath registers carry no reset; only the valid bits decide whether their contents matter.
    always_ff @(posedge clk) begin
        if (advance) begin
            a_q <= a;
            b_q <= b;
            p_q <= p_d;
        end
    end

    // NOTE: every sequential assignment is non-blocking so all stages shift on the same edge without ordering races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            res_q     <= '0;
            sat_pos_q <= 1'b0;
            sat_neg_q <= 1'b0;
        end else if (advance) begin
            v1_q      <= in_valid;
            v2_q      <= v1_q;
            v3_q      <= v2_q;
            sat_pos_q <= v2_q && sat_pos_d;
            sat_neg_q <= v2_q && sat_neg_d;
            if (v2_q) begin
                res_q <= res_d;
            end
        end
    end

    // Clear wins over a simultaneous saturated handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end else if (sat_event) begin
            ovf_q <= 1'b1;
        end
    end

`ifdef FX_MULT_SAT_COUNT_EN
    logic [CNT_W-1:0] sat_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if (clr_ovf) begin
            sat_cnt_q <= '0;
        end else if (sat_event && (sat_cnt_q != '1)) begin
            sat_cnt_q <= sat_cnt_q + CNT_W'(1);
        end
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = '0;
`endif

    assign in_ready   = advance;
    assign out_valid  = v3_q;
    assign resultado  = res_q;
    assign sat_pos    = sat_pos_q;
    assign sat_neg    = sat_neg_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_fx_mult_sat_pipe.sv
// Self-checking bench for fx_mult_sat_pipe: directed vector table, backpressure/reset/clear sequences,
// and randomized streaming checked against an arithmetic reference model.
module tb_fx_mult_sat_pipe;

    localparam int N      = 25;
    localparam int F      = 14;
    localparam int TB_RND = 1;
    localparam int CNT_W  = 16;
`ifdef FX_MULT_SAT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a, b;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     resultado;
    logic             sat_pos, sat_neg;
    logic             clr_ovf;
    logic             ovf_sticky;
    logic [CNT_W-1:0] sat_count;

    fx_mult_sat_pipe #(.N(N), .F(F), .RND(TB_RND), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .resultado(resultado), .sat_pos(sat_pos), .sat_neg(sat_neg),
        .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [N-1:0] a, b, res;
        logic         pos, neg;
    } vec_t;

    typedef struct {
        logic [N-1:0] res;
        logic         pos, neg;
    } exp_t;

    int n_pass  = 0;
    int n_total = 0;

    logic             exp_sticky = 1'b0;
    int               exp_cnt    = 0;
    exp_t             sb[$];
    int               n_out;
    bit               held_v = 1'b0;
    logic [N+1:0]     held_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [N-1:0] to_n(input longint v);
        return N'(v);
    endfunction

    function automatic vec_t mk(input string nm, input longint va, vb, vr, input bit p, n);
        vec_t v;
        v.name = nm; v.a = to_n(va); v.b = to_n(vb); v.res = to_n(vr); v.pos = p; v.neg = n;
        return v;
    endfunction

    // Reference: exact product, optional half-LSB bias, floor divide, clamp to N-bit signed range.
    function automatic exp_t model(input logic [N-1:0] x, y);
        exp_t   e;
        longint p, q, yv, maxv, minv;
        p    = longint'($signed(x)) * longint'($signed(y));
        q    = p + ((TB_RND != 0) ? (longint'(1) << (F - 1)) : 0);
        yv   = q >>> F;
        maxv = (longint'(1) << (N - 1)) - 1;
        minv = -(longint'(1) << (N - 1));
        e.pos = (yv > maxv);
        e.neg = (yv < minv);
        if (e.pos)      e.res = to_n(maxv);
        else if (e.neg) e.res = to_n(minv);
        else            e.res = to_n(yv);
        return e;
    endfunction

    function automatic logic [N-1:0] rand_operand();
        logic [N-1:0] v;
        v = N'($urandom());
        return N'($signed(v) >>> $urandom_range(0, 16));
    endfunction

    function automatic logic [CNT_W-1:0] exp_count();
        return CNT_EN ? CNT_W'(exp_cnt) : '0;
    endfunction

    task automatic note_delivery(input bit sat, input bit clr);
        if (clr) begin
            exp_sticky = 1'b0;
            exp_cnt    = 0;
        end else if (sat) begin
            exp_sticky = 1'b1;
            if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        end
    endtask

    // Present one operand pair on an idle pipe; returns at the negedge where out_valid is first seen.
    task automatic run_one(input logic [N-1:0] va, vb, output logic [N-1:0] r,
                           output logic sp, sn, output int lat);
        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = resultado; sp = sat_pos; sn = sat_neg;
    endtask

    // One streaming cycle: drive, then check status, held output, handshake and acceptance.
    task automatic step(input bit iv, input logic [N-1:0] va, vb, input bit ordy, input bit clr);
        exp_t e;
        @(negedge clk);
        in_valid = iv; a = va; b = vb; out_ready = ordy; clr_ovf = clr;
        #1;
        check("sticky", 64'(ovf_sticky), 64'(exp_sticky));
        check("sat_count", 64'(sat_count), 64'(exp_count()));
        if (held_v) check("hold_value", {out_valid, resultado, sat_pos, sat_neg}, {1'b1, held_val});
        if (out_valid && !ordy) check("stall_in_ready", 64'(in_ready), 64'd0);
        if (!out_valid) check("idle_flags", {sat_pos, sat_neg}, 2'b00);
        if (out_valid && ordy) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("stream_out", {resultado, sat_pos, sat_neg}, {e.res, e.pos, e.neg});
                n_out++;
                note_delivery(e.pos || e.neg, clr);
            end
        end else begin
            note_delivery(1'b0, clr);
        end
        held_v   = out_valid && !ordy;
        held_val = {resultado, sat_pos, sat_neg};
        if (iv && in_ready) sb.push_back(model(va, vb));
    endtask

    vec_t         tbl[9];
    logic [N-1:0] r;
    logic         sp, sn;
    int           lat, seen;

    initial begin
        tbl[0] = mk("basic_mult",  24576, 32768, 49152, 0, 0);
        tbl[1] = mk("pos_sat",     16384000, 32768, 'h0FFFFFF, 1, 0);
        tbl[2] = mk("neg_sat",     -16384000, 32768, 'h1000000, 0, 1);
        tbl[3] = mk("rnd_pos",     1, 8192, (TB_RND != 0) ? 1 : 0, 0, 0);
        tbl[4] = mk("rnd_neg",     -1, 8192, (TB_RND != 0) ? 0 : 'h1FFFFFF, 0, 0);
        tbl[5] = mk("min_squared", -16777216, -16777216, 'h0FFFFFF, 1, 0);
        tbl[6] = mk("rnd_push",    1082401, 253952, 'h0FFFFFF, (TB_RND != 0), 0);
        tbl[7] = mk("min_exact",   -16777216, 16384, 'h1000000, 0, 0);
        tbl[8] = mk("zero",        0, -12345, 0, 0, 0);

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", {resultado, sat_pos, sat_neg, ovf_sticky}, '0);
        check("rst_sat_count", 64'(sat_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_one(tbl[i].a, tbl[i].b, r, sp, sn, lat);
            check({tbl[i].name, "_latency"}, 64'(lat), 64'd3);
            check({tbl[i].name, "_result"}, 64'(r), 64'(tbl[i].res));
            check({tbl[i].name, "_flags"}, {sp, sn}, {tbl[i].pos, tbl[i].neg});
            note_delivery(tbl[i].pos || tbl[i].neg, 1'b0);
            @(negedge clk);
            check({tbl[i].name, "_sticky"}, 64'(ovf_sticky), 64'(exp_sticky));
            check({tbl[i].name, "_count"}, 64'(sat_count), 64'(exp_count()));
            check({tbl[i].name, "_drained"}, 64'(out_valid), 64'd0);
        end

        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        note_delivery(1'b0, 1'b1);
        check("clear_sticky", 64'(ovf_sticky), 64'd0);
        check("clear_count", 64'(sat_count), 64'd0);

        // Backpressure: six back-to-back samples, out_ready low in cycles 4..7.
        n_out = 0;
        for (int c = 0, k = 0; c < 20; c++) begin
            logic [N-1:0] va, vb;
            va = rand_operand(); vb = rand_operand();
            if (k < 6 && !(out_valid && !(c < 4 || c > 7))) k++;
            step(k <= 6 && c < 12 && sb.size() + n_out < 6, va, vb, !(c >= 4 && c <= 7), 1'b0);
        end
        check("bp_count", 64'(n_out), 64'd6);
        check("bp_empty", 64'(sb.size()), 64'd0);

        // Randomized streaming with random backpressure and occasional clears.
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 9) < 7, rand_operand(), rand_operand(),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end
        for (int c = 0; c < 20; c++) step(1'b0, '0, '0, 1'b1, 1'b0);
        check("random_drained", 64'(sb.size()), 64'd0);
        held_v = 1'b0;

        // Clear colliding with a saturated handshake.
        run_one(to_n(16384000), to_n(32768), r, sp, sn, lat);
        note_delivery(1'b1, 1'b0);
        @(negedge clk);
        check("pre_collide_sticky", 64'(ovf_sticky), 64'd1);
        check("pre_collide_count", 64'(sat_count), 64'(exp_count()));
        run_one(to_n(-16384000), to_n(32768), r, sp, sn, lat);
        check("collide_flag", {sp, sn}, 2'b01);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        note_delivery(1'b0, 1'b1);
        check("collide_sticky", 64'(ovf_sticky), 64'd0);
        check("collide_count", 64'(sat_count), 64'd0);

        // Reset with three saturating samples in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = to_n(16384000); b = to_n(32768);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("prereset_full", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sticky", 64'(ovf_sticky), 64'd0);
        check("midrst_count", 64'(sat_count), 64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_nothing_emitted", 64'(seen), 64'd0);
        check("midrst_sticky_after", 64'(ovf_sticky), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fx_mult_sat_pipe.md
Name: fx_mult_sat_pipe

Overview:
- Pipelined signed fixed-point multiplier. Takes two N-bit Q(N-F-1).F operands, forms the 2N-bit product, then rounds or truncates it back to N bits with saturation.
- Successor to the combinational product truncator. Adds a 3-stage pipeline, valid/ready backpressure, selectable rounding, and overflow flagging/counting.
- Sits between the filter coefficient/sample path and the accumulator in the datapath.

Parameters:
- N, 25, total word width of operands and result (two's complement).
- F, 14, fractional bits of operands and result.
- RND, 1, 0 = truncate toward -inf; 1 = round half up (add 2^(F-1) before truncation).
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  N  signed operand A.
- b  in  N  signed operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- resultado  out  N  signed saturated result, same Q format as inputs.
- sat_pos  out  1  result at out_valid was clamped to +max.
- sat_neg  out  1  result at out_valid was clamped to -max.
- clr_ovf  in  1  clears ovf_sticky and sat_count.
- ovf_sticky  out  1  set by any saturation event since last clear.
- sat_count  out  CNT_W  number of saturated results delivered (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a rising clk edge):
  - all valid bits, resultado, sat_pos, sat_neg, ovf_sticky and sat_count go to 0.
  - Reset mid-operation discards every in-flight sample; nothing is emitted.
- Pipeline: S1 registers a and b. S2 registers the 2N-bit signed product P. S3 performs round/saturate and registers the output.
- Latency: 3 clk from an accepted input to out_valid. Throughput: 1 sample per clk when not stalled.
- Stall = out_valid && !out_ready. When stalled:
  - all stages hold;
  - in_ready = !stall;
  - a transfer occurs when in_valid && in_ready.
- When not stalled, every stage advances; empty stages propagate as bubbles (valid=0).
- Rounding (S3): Q = P + (RND ? 2^(F-1) : 0), computed at 2N+1 bits so it cannot wrap.
- Overflow check is performed on Q:
  - no overflow iff bits Q[2N:N+F-1] are all equal;
  - result is then Q[N+F-1:F].
- Positive overflow (Q sign 0): resultado = {0, all ones} = +max; sat_pos=1.
- Negative overflow (Q sign 1): resultado = {1, all zeros} = -max; sat_neg=1.
- sat_pos and sat_neg are never both 1. Both are 0 when out_valid=0.
- Rounding that pushes +max past range saturates; -max inputs squared saturate to +max.
- ovf_sticky and sat_count update only on an output handshake (out_valid && out_ready) carrying a saturated result.
- clr_ovf has priority over a simultaneous saturation event: the result is 0 after that edge and the event is lost.
- resultado holds its last value when out_valid=0.

Optional Feature:
- Macro: FX_MULT_SAT_COUNT_EN.
- Defined: sat_count increments by 1 per saturated handshake. It saturates at 2^CNT_W-1 (no wrap) and is cleared by clr_ovf or reset.
- Undefined: counter logic is omitted; sat_count is tied to 0. ovf_sticky behaviour is unchanged.

Test Plan (N=25, F=14, 1.0 = 16384):
- Basic multiply: a=24576 (1.5), b=32768 (2.0), out_ready=1 → resultado=49152 (3.0) exactly 3 clk after acceptance; sat flags 0.
- Positive saturation: a=16384000 (1000.0), b=32768 → resultado=0x0FFFFFF, sat_pos=1, ovf_sticky=1, sat_count=1. Repeat with a=-16384000 → 0x1000000, sat_neg=1, sat_count=2.
- Rounding: a=1, b=8192 → 1 with RND=1 and 0 with RND=0. With a=-1, b=8192 → 0 with RND=1 and 0x1FFFFFF (-1 LSB) with RND=0.
- Backpressure: stream 6 back-to-back samples with out_ready low for cycles 4-7. Required: in_ready=0 during stall, no sample lost or duplicated, outputs in order, values unchanged while held.
- Reset mid-stream: pull rst_n low one cycle with 3 samples in flight. Required: out_valid=0 next cycle, none of the 3 emitted, ovf_sticky=0, sat_count=0.
- Clear collision: assert clr_ovf in the same cycle as a saturated handshake → ovf_sticky=0, sat_count=0 afterwards. Build without FX_MULT_SAT_COUNT_EN → sat_count stays 0 throughout.
